// File: rtl/mdio_master.sv
// MDIO management master: serialises one Clause 22 / Clause 45 frame per
// accepted request, generates a frame-gated MDC and returns read data.
module mdio_master #(
   parameter int DIV          = 16,
   parameter int PRE_LEN      = 32,
   parameter int SUPPRESS_PRE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mdc_o,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_st,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_phy,
   input  logic [4:0]  req_reg,
   input  logic [15:0] req_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        busy
);

   localparam int P  = (SUPPRESS_PRE != 0) ? 0 : PRE_LEN;
   localparam int PW = $clog2(DIV);

   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_RISE = PW'(DIV / 2 - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);

   // Frame-absolute index of the last bit of each section
   localparam logic [5:0] B_PRE  = 6'((P > 0) ? P - 1 : 0);
   localparam logic [5:0] B_HDR  = 6'(P + 13);
   localparam logic [5:0] B_TA   = 6'(P + 15);
   localparam logic [5:0] B_DATA = 6'(P + 31);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ph;
   logic [5:0]    bidx;
   logic          armed;
   logic          is_rd;
   logic [31:0]   sh;
   logic [15:0]   rd_sh;
   logic          active, accept, bit_end, rd_frame, last_data;

   assign active    = (state == S_PRE) || (state == S_HDR) || (state == S_TA) || (state == S_DATA);
   assign req_ready = armed && ((state == S_IDLE) || (state == S_DONE));
   assign accept    = req_valid && req_ready;
   assign bit_end   = active && (ph == PH_LAST);
   assign last_data = (state == S_DATA) && bit_end && (bidx == B_DATA);
   assign rd_frame  = ((req_st == 2'b01) && (req_op == 2'b10)) ||
                      ((req_st == 2'b00) && req_op[1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: state_nxt = accept ? ((P > 0) ? S_PRE : S_HDR) : S_IDLE;
         S_PRE:          if (bit_end && (bidx == B_PRE))  state_nxt = S_HDR;
         S_HDR:          if (bit_end && (bidx == B_HDR))  state_nxt = S_TA;
         S_TA:           if (bit_end && (bidx == B_TA))   state_nxt = S_DATA;
         S_DATA:         if (bit_end && (bidx == B_DATA)) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mdc_o     = active && (ph >= PH_HALF);
      busy      = active;
      mdio_o    = 1'b1;
      mdio_oe   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_PRE: mdio_oe = 1'b1;
         S_HDR: begin
            mdio_oe = 1'b1;
            mdio_o  = sh[31];
         end
         S_TA, S_DATA: begin
            mdio_oe = !is_rd;
            mdio_o  = is_rd ? 1'b1 : sh[31];
         end
         S_DONE: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph       <= '0;
         bidx     <= '0;
         armed    <= 1'b0;
         rsp_data <= '0;
      end else begin
         armed <= 1'b1;
         if (accept) begin
            ph   <= '0;
            bidx <= '0;
         end else if (active) begin
            ph <= bit_end ? '0 : ph + 1'b1;
            if (bit_end) bidx <= bidx + 1'b1;
         end
         // Final read sample lands mid-bit, so rd_sh is complete at the last bit edge
         if (last_data) rsp_data <= is_rd ? rd_sh : 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sh    <= {req_st, req_op, req_phy, req_reg, 2'b10, req_data};
         is_rd <= rd_frame;
      end else if (bit_end && (state != S_PRE)) begin
         sh <= {sh[30:0], 1'b0};
      end
      // Sample on the edge that raises MDC
      if ((state == S_DATA) && (ph == PH_RISE)) rd_sh <= {rd_sh[14:0], mdio_i};
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: four instances cover the default preamble,
// zero/suppressed preamble and a short-preamble, fast-MDC configuration.
`timescale 1ns/1ps
module tb_mdio_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [4];
   logic        mdc       [4];
   logic        mdio_in   [4];
   logic        mdio_out  [4];
   logic        mdio_en   [4];
   logic        req_valid [4];
   logic        req_ready [4];
   logic [1:0]  req_st    [4];
   logic [1:0]  req_op    [4];
   logic [4:0]  req_phy   [4];
   logic [4:0]  req_reg   [4];
   logic [15:0] req_data  [4];
   logic        rsp_valid [4];
   logic [15:0] rsp_data  [4];
   logic        busy      [4];

   int DIVV [4] = '{16, 4, 8, 16};
   int PV   [4] = '{32, 0, 16, 0};

   int vectors     = 0;
   int miscompares = 0;

   mdio_master #(.DIV(16), .PRE_LEN(32), .SUPPRESS_PRE(0)) u0 (
      .clk(clk), .rst_n(rst_n[0]), .mdc_o(mdc[0]), .mdio_i(mdio_in[0]), .mdio_o(mdio_out[0]),
      .mdio_oe(mdio_en[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_st(req_st[0]),
      .req_op(req_op[0]), .req_phy(req_phy[0]), .req_reg(req_reg[0]), .req_data(req_data[0]),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0]));

   mdio_master #(.DIV(4), .PRE_LEN(0), .SUPPRESS_PRE(0)) u1 (
      .clk(clk), .rst_n(rst_n[1]), .mdc_o(mdc[1]), .mdio_i(mdio_in[1]), .mdio_o(mdio_out[1]),
      .mdio_oe(mdio_en[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_st(req_st[1]),
      .req_op(req_op[1]), .req_phy(req_phy[1]), .req_reg(req_reg[1]), .req_data(req_data[1]),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1]));

   mdio_master #(.DIV(8), .PRE_LEN(16), .SUPPRESS_PRE(0)) u2 (
      .clk(clk), .rst_n(rst_n[2]), .mdc_o(mdc[2]), .mdio_i(mdio_in[2]), .mdio_o(mdio_out[2]),
      .mdio_oe(mdio_en[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_st(req_st[2]),
      .req_op(req_op[2]), .req_phy(req_phy[2]), .req_reg(req_reg[2]), .req_data(req_data[2]),
      .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .busy(busy[2]));

   mdio_master #(.DIV(16), .PRE_LEN(32), .SUPPRESS_PRE(1)) u3 (
      .clk(clk), .rst_n(rst_n[3]), .mdc_o(mdc[3]), .mdio_i(mdio_in[3]), .mdio_o(mdio_out[3]),
      .mdio_oe(mdio_en[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]), .req_st(req_st[3]),
      .req_op(req_op[3]), .req_phy(req_phy[3]), .req_reg(req_reg[3]), .req_data(req_data[3]),
      .rsp_valid(rsp_valid[3]), .rsp_data(rsp_data[3]), .busy(busy[3]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {mdc, mdio_o, mdio_oe, req_ready, busy, rsp_valid, rsp_data}
   function automatic logic [21:0] pins(input int u);
      return {mdc[u], mdio_out[u], mdio_en[u], req_ready[u], busy[u], rsp_valid[u], rsp_data[u]};
   endfunction

   // Issues one request and walks the whole frame, ending in the completion cycle.
   task automatic frame(input int u, input logic [1:0] st, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] data,
                        input logic [15:0] rdval, input bit hold);
      int dv, p, n, wait_n, pulses, bad_bits, bad_mdc, bad_ctl;
      logic rd, prev_mdc, eo, eoe;
      logic [31:0] hdr;
      dv  = DIVV[u];
      p   = PV[u];
      n   = p + 32;
      rd  = ((st == 2'b01) && (op == 2'b10)) || ((st == 2'b00) && op[1]);
      hdr = {st, op, phy, rg, 2'b10, data};
      wait_n = 0;
      while (req_ready[u] !== 1'b1 && wait_n < 200) begin
         @(posedge clk); #1;
         wait_n++;
      end
      chk("ready_before_req", 64'(req_ready[u]), 64'd1);
      req_st[u] = st; req_op[u] = op; req_phy[u] = phy; req_reg[u] = rg; req_data[u] = data;
      req_valid[u] = 1'b1;
      @(posedge clk); #1;
      chk("accept_busy_ready", 64'({busy[u], req_ready[u]}), 64'd2);
      if (!hold) req_valid[u] = 1'b0;
      pulses = 0; bad_bits = 0; bad_mdc = 0; bad_ctl = 0;
      prev_mdc = mdc[u];
      for (int k = 0; k < n; k++) begin
         eoe = (k < p + 14) ? 1'b1 : !rd;
         eo  = (k < p) ? 1'b1 : hdr[31 - (k - p)];
         mdio_in[u] = (rd && k >= p + 16) ? rdval[15 - (k - p - 16)] : 1'b1;
         if (hold) begin
            req_st[u] = 2'($urandom); req_op[u] = 2'($urandom); req_phy[u] = 5'($urandom);
            req_reg[u] = 5'($urandom); req_data[u] = 16'($urandom);
         end
         for (int c = 0; c < dv; c++) begin
            if (mdc[u] !== (c >= dv / 2)) bad_mdc++;
            if (mdc[u] === 1'b1 && prev_mdc === 1'b0) pulses++;
            prev_mdc = mdc[u];
            if (mdio_en[u] !== eoe || (eoe && mdio_out[u] !== eo)) bad_bits++;
            if (req_ready[u] !== 1'b0 || busy[u] !== 1'b1 || rsp_valid[u] !== 1'b0) bad_ctl++;
            @(posedge clk); #1;
         end
      end
      mdio_in[u] = 1'b1;
      chk("mdc_pulses", 64'(pulses), 64'(n));
      chk("mdc_duty_errs", 64'(bad_mdc), 64'd0);
      chk("stream_errs", 64'(bad_bits), 64'd0);
      chk("ctl_during_frame_errs", 64'(bad_ctl), 64'd0);
      chk("rsp_valid_done", 64'(rsp_valid[u]), 64'd1);
      chk("rsp_data_done", 64'(rsp_data[u]), 64'(rd ? rdval : 16'h0000));
      chk("done_ready_busy", 64'({req_ready[u], busy[u], mdio_en[u]}), 64'd4);
   endtask

   initial begin
      int bad;
      for (int u = 0; u < 4; u++) begin
         rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_st[u] = '0; req_op[u] = '0;
         req_phy[u] = '0; req_reg[u] = '0; req_data[u] = '0; mdio_in[u] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) chk("reset_pins", 64'(pins(u)), 64'({1'b0, 1'b1, 4'b0, 16'h0}));
      for (int u = 0; u < 4; u++) rst_n[u] = 1'b1;
      #1;
      chk("ready_low_after_release", 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
      for (int u = 0; u < 4; u++) chk("ready_first_edge", 64'(req_ready[u]), 64'd1);

      // C22 write then C22 read on the default configuration
      frame(0, 2'b01, 2'b01, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0);
      frame(0, 2'b01, 2'b10, 5'h02, 5'h02, 16'h0000, 16'h0141, 1'b0);
      @(posedge clk); #1;
      chk("single_rsp_pulse", 64'({rsp_valid[0], busy[0]}), 64'd0);

      // Request held with churning fields, next request taken only on completion
      frame(0, 2'b01, 2'b01, 5'h04, 5'h09, 16'hBEEF, 16'h0000, 1'b1);
      frame(0, 2'b01, 2'b01, 5'h1F, 5'h1F, 16'h1234, 16'h0000, 1'b0);

      // Clause 45 address + read, back-to-back, preamble suppressed
      frame(3, 2'b00, 2'b00, 5'h03, 5'h01, 16'h8000, 16'h0000, 1'b0);
      frame(3, 2'b00, 2'b11, 5'h03, 5'h01, 16'h0000, 16'hA5A5, 1'b0);

      // Parameter sweep: DIV=4/P=0 and DIV=8/P=16
      frame(1, 2'b01, 2'b01, 5'h1F, 5'h10, 16'hA55A, 16'h0000, 1'b0);
      frame(1, 2'b01, 2'b10, 5'h1F, 5'h10, 16'h0000, 16'h3C3C, 1'b0);
      frame(2, 2'b01, 2'b01, 5'h07, 5'h1B, 16'h0F0F, 16'h0000, 1'b0);
      frame(2, 2'b00, 2'b10, 5'h07, 5'h1B, 16'h0000, 16'hC0DE, 1'b0);

      // Reset in mid-read at bit 40 while MDC is high
      req_st[0] = 2'b01; req_op[0] = 2'b10; req_phy[0] = 5'h02; req_reg[0] = 5'h03;
      req_data[0] = 16'h0000; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (40 * 16 + 9) @(posedge clk);
      #1;
      chk("mid_frame_busy_mdc", 64'({busy[0], mdc[0]}), 64'd3);
      rst_n[0] = 1'b0;
      #1;
      chk("mid_frame_reset_pins", 64'(pins(0)), 64'({1'b0, 1'b1, 4'b0, 16'h0}));
      bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
      end
      rst_n[0] = 1'b1;
      #1;
      chk("ready_low_after_rerelease", 64'(req_ready[0]), 64'd0);
      repeat (600) begin
         @(posedge clk); #1;
         if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
      end
      chk("no_rsp_after_abort", 64'(bad), 64'd0);
      frame(0, 2'b01, 2'b01, 5'h05, 5'h11, 16'h00FF, 16'h0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
# mdio_master

Parametrised MDIO (IEEE 802.3 management) master that serialises one Clause 22 or Clause 45 management frame per request, generates MDC, and returns read data. It sits between the register/host interface of the MAC subsystem and the external PHY MDIO pins, which are driven through an external tri-state buffer. Compared with the earlier single-mode shifter, it adds:

- a valid/ready request handshake;
- Clause 45 start/opcodes;
- configurable preamble, including suppression;
- MDC gated to frame activity.

## Interface
Parameters:
- DIV, 16, clk cycles per MDC period; even, ≥4.
- PRE_LEN, 32, preamble length in bits; 0..32.
- SUPPRESS_PRE, 0, when 1 the preamble is omitted regardless of PRE_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mdc_o  out  1  MDC.
- mdio_i  in  1  MDIO input from pad.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable (1 = drive).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_st  in  2  ST field (01 = C22, 00 = C45).
- req_op  in  2  OP field.
- req_phy  in  5  PHYAD / PRTAD.
- req_reg  in  5  REGAD / DEVAD.
- req_data  in  16  write data or C45 address.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  16  read data, 0 for non-reads.
- busy  out  1  frame in progress.

## Operation
- Accept a request on the clk edge where req_valid && req_ready. Latch all req_* fields at that edge.
- Read frames: st==01 && op==10, or st==00 && op[1]==1. All other frames are write-type.
- Frame bit order, MSB first:
  - P = (SUPPRESS_PRE ? 0 : PRE_LEN) preamble ones.
  - ST(2), OP(2), PHY(5), REG(5).
  - TA(2).
  - DATA(16).
- Total frame length N = P + 32 bits.
- State machine:
  - IDLE: req_ready=1, busy=0.
  - IDLE → PRE when P>0, otherwise IDLE → HDR.
  - PRE (P bits) → HDR (14 bits) → TA (2 bits) → DATA (16 bits) → DONE → IDLE.
- PRE, HDR: mdio_oe=1, mdio_o = current bit.
- TA:
  - Write-type: drive 1 then 0.
  - Read: mdio_oe=0 for both bits.
- DATA:
  - Write-type: drive req_data[15..0].
  - Read: mdio_oe=0; shift mdio_i into a 16-bit register, first sample into bit 15.
- DONE (1 cycle): rsp_valid=1. rsp_data = sampled word for reads, 16'h0000 for write-type. mdio_oe=0.
- Idle pin state: mdc_o=0, mdio_oe=0, mdio_o=1. MDC toggles only in PRE..DATA.
- req_valid while busy: ignored, no queueing. The requester holds it until ready.
- No PHY presence check: a read of an absent PHY returns 16'hFFFF, given the external pull-up.

## Timing
- Reset values (asynchronous, while rst_n=0): mdc_o=0, mdio_o=1, mdio_oe=0, req_ready=0, busy=0, rsp_valid=0, rsp_data=0, state IDLE, phase counter 0.
- Reset recovery: req_ready rises on the first clk edge after rst_n deasserts.
- req_ready falls and busy rises on the accept edge.
- Let t0 = the cycle after accept. Bit k occupies cycles t0+k·DIV .. t0+k·DIV+DIV-1.
- mdio_o and mdio_oe change only at bit start (MDC low phase).
- mdc_o: 0 for the first DIV/2 cycles of each bit, 1 for the last DIV/2.
- mdio_i is sampled on the clk edge where mdc_o goes 0→1.
- rsp_valid pulses in cycle t0+N·DIV. req_ready=1 and busy=0 in the same cycle.
- Back-to-back: the earliest next accept is on that same edge, so minimum request-to-request spacing is N·DIV+1 cycles.
- Reset mid-frame: outputs return immediately to reset values and the frame is abandoned. No rsp_valid is issued.
- Counters: phase counter width clog2(DIV); bit counter 6 bits (maximum 64).

## Test plan
- C22 write, DIV=16, P=32, phy=5'h01, reg=5'h00, data=16'h1140:
  - 64 MDC pulses.
  - Captured serial stream = 32×1, 01, 01, 00001, 00000, 10, 0001000101000000.
  - rsp_valid exactly at cycle t0+1024.
  - mdio_oe=1 throughout the frame.
- C22 read, phy=5'h02, reg=5'h02, PHY model returns 16'h0141 on rising MDC:
  - mdio_oe=0 from bit P+14 onward.
  - rsp_data=16'h0141 with a single rsp_valid pulse.
- C45 sequence, SUPPRESS_PRE=1: address (st=00, op=00, data=16'h8000), then read (op=11) back-to-back:
  - Each frame 32 MDC pulses.
  - Second accept on the first frame's rsp_valid cycle.
  - Read classified as read; model data 16'hA5A5 returned.
- Handshake: req_valid held asserted with changing fields during a frame:
  - Frame contents are unchanged from the latched request.
  - The next request is accepted only when req_ready=1.
- Reset: rst_n pulsed low at bit 40 of a read:
  - Outputs go to reset values within the reset cycle.
  - No rsp_valid.
  - A new write after release completes normally.
- Parameter sweep DIV=4, PRE_LEN=0 and DIV=8, PRE_LEN=16:
  - MDC high/low each DIV/2 cycles.
  - Frame lengths 32 and 48 bits.
